// File: rtl/axis_pkt_rr_arbiter_if.sv
// AXI-Stream bundle between NUM_SRC sources, the packet arbiter and the FIFO input.
// Pure wiring, no latency.
// Backpressure is carried by s_tready (to sources) and m_tready (from the FIFO).
`timescale 1ns/1ps
interface axis_pkt_rr_arbiter_if #(
   parameter int NUM_SRC = 4,
   parameter int DATA_W  = 8
);
   logic [NUM_SRC*DATA_W-1:0] s_tdata;
   logic [NUM_SRC-1:0]        s_tvalid;
   logic [NUM_SRC-1:0]        s_tlast;
   logic [NUM_SRC-1:0]        s_tready;
   logic [DATA_W-1:0]         m_tdata;
   logic                      m_tvalid;
   logic                      m_tlast;
   logic                      m_tready;

   // Arbiter view: consumes the source streams, produces the FIFO stream.
   modport slave (
      input  s_tdata, s_tvalid, s_tlast, m_tready,
      output s_tready, m_tdata, m_tvalid, m_tlast
   );

   // Surrounding view: sources drive s_*, the FIFO drives m_tready.
   modport master (
      output s_tdata, s_tvalid, s_tlast, m_tready,
      input  s_tready, m_tdata, m_tvalid, m_tlast
   );
endinterface

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter feeding the byte FIFO from NUM_SRC AXI-Stream sources.
// Latency: request in IDLE cycle N -> first beat in cycle N+1; data path is combinational in XFER; one IDLE bubble after each tlast.
// Backpressure: m_tready passes straight to the granted source's s_tready; grant held through stalls and gaps.
// Optional beat limit built when ARB_PKT_LIMIT_EN is defined (forces tlast on beat MAX_PKT_LEN).
`timescale 1ns/1ps
module axis_pkt_rr_arbiter #(
   parameter int  NUM_SRC     = 4,
   parameter int  DATA_W      = 8,
   parameter int  MAX_PKT_LEN = 2048,
   localparam int GW          = $clog2(NUM_SRC)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   axis_pkt_rr_arbiter_if.slave  bus,
   output logic                  fifo_w_en,
   output logic [GW-1:0]         grant_id,
   output logic                  busy,
   output logic                  pkt_trunc
);

   // Reject configurations the round-robin scan and beat counter are not sized for.
   if (NUM_SRC < 2 || NUM_SRC > 8 || MAX_PKT_LEN < 2) begin : g_bad_param
      $error("axis_pkt_rr_arbiter: NUM_SRC must be 2..8 and MAX_PKT_LEN at least 2");
   end

   typedef enum logic {IDLE, XFER} state_t;

   state_t        state;
   logic [GW-1:0] last_grant;
   logic [GW-1:0] pick;
   logic [GW-1:0] cand;
   logic          any_req;
   logic          src_last;
   logic          force_last;
   logic          beat;

`ifdef ARB_PKT_LIMIT_EN
   localparam int CW = $clog2(MAX_PKT_LEN + 1);
   logic [CW-1:0] beat_cnt;

   // The beat that would take the packet past MAX_PKT_LEN beats is forced to close it.
   assign force_last = (beat_cnt == CW'(MAX_PKT_LEN - 1));
   assign pkt_trunc  = beat & force_last & ~src_last;
`else
   assign force_last = 1'b0;
   assign pkt_trunc  = 1'b0;
`endif

   assign beat = (state == XFER) & bus.m_tvalid & bus.m_tready;

   // Round-robin pick: scan from far to near so the source closest after last_grant wins.
   always_comb begin
      pick    = '0;
      cand    = '0;
      any_req = |bus.s_tvalid;
      for (int k = NUM_SRC; k >= 1; k--) begin
         cand = GW'((int'(last_grant) + k) % NUM_SRC);
         if (bus.s_tvalid[cand]) begin
            pick = cand;
         end
      end
   end

   // Output mux: only the granted source is visible and only it sees the FIFO's ready.
   always_comb begin
      bus.m_tdata  = '0;
      bus.m_tvalid = 1'b0;
      bus.m_tlast  = 1'b0;
      bus.s_tready = '0;
      src_last     = 1'b0;
      if (state == XFER) begin
         src_last               = bus.s_tlast[grant_id];
         bus.m_tdata            = bus.s_tdata[grant_id*DATA_W +: DATA_W];
         bus.m_tvalid           = bus.s_tvalid[grant_id];
         bus.m_tlast            = src_last | force_last;
         bus.s_tready[grant_id] = bus.m_tready;
      end
   end

   // Grant FSM: lock a source for a whole packet, release on the closing beat.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         grant_id   <= '0;
         last_grant <= GW'(NUM_SRC - 1);
         busy       <= 1'b0;
         fifo_w_en  <= 1'b0;
`ifdef ARB_PKT_LIMIT_EN
         beat_cnt   <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state     <= XFER;
                  grant_id  <= pick;
                  busy      <= 1'b1;
                  fifo_w_en <= 1'b1;
`ifdef ARB_PKT_LIMIT_EN
                  beat_cnt  <= '0;
`endif
               end
            end
            XFER: begin
               if (beat) begin
`ifdef ARB_PKT_LIMIT_EN
                  beat_cnt <= beat_cnt + CW'(1);
`endif
                  if (bus.m_tlast) begin
                     state      <= IDLE;
                     last_grant <= grant_id;
                     busy       <= 1'b0;
                     fifo_w_en  <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Directed bench for axis_pkt_rr_arbiter: reset, lone source, round-robin, stall, reset mid-packet, beat limit.
// Sources are queue-driven (inputs change 1 ns after the rising edge); outputs are sampled at the falling edge.
// Expected streams and cycle spacing are written out by hand for each scenario.
`timescale 1ns/1ps
module tb_axis_pkt_rr_arbiter;
   localparam int NUM_SRC     = 4;
   localparam int DATA_W      = 8;
   localparam int MAX_PKT_LEN = 4;

   typedef struct packed {
      logic       last;
      logic [7:0] dat;
   } beat_t;

   typedef struct packed {
      int         src;
      int         cyc;
      logic       last;
      logic       trunc;
      logic [7:0] dat;
   } obs_t;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       fifo_w_en;
   logic [1:0] grant_id;
   logic       busy;
   logic       pkt_trunc;

   beat_t              srcq[NUM_SRC][$];
   obs_t               outq[$];
   logic [NUM_SRC-1:0] pop_req;
   int                 cyc;
   int                 trunc_cnt;
   int                 n_chk = 0;
   int                 n_err = 0;

   axis_pkt_rr_arbiter_if #(.NUM_SRC(NUM_SRC), .DATA_W(DATA_W)) bus ();

   axis_pkt_rr_arbiter #(
      .NUM_SRC    (NUM_SRC),
      .DATA_W     (DATA_W),
      .MAX_PKT_LEN(MAX_PKT_LEN)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .bus      (bus.slave),
      .fifo_w_en(fifo_w_en),
      .grant_id (grant_id),
      .busy     (busy),
      .pkt_trunc(pkt_trunc)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   task automatic at_pos();
      @(posedge clk);
      #1;
   endtask

   task automatic push_beat(input int s, input logic [7:0] d, input logic l);
      beat_t e;
      e.last = l;
      e.dat  = d;
      srcq[s].push_back(e);
   endtask

   task automatic wait_beats(input int n, input int budget, input string tag);
      int k = 0;
      while (outq.size() < n && k < budget) begin
         at_neg();
         k++;
      end
      chk(tag, outq.size(), n);
   endtask

   // Source models: retire the head beat after a handshake, present the next one.
   initial begin : src_drv
      beat_t hd;
      bus.s_tdata  = '0;
      bus.s_tvalid = '0;
      bus.s_tlast  = '0;
      forever begin
         at_pos();
         for (int i = 0; i < NUM_SRC; i++) begin
            if (pop_req[i] && srcq[i].size() > 0) srcq[i].delete(0);
            if (srcq[i].size() > 0) begin
               hd = srcq[i][0];
               bus.s_tvalid[i]                  = 1'b1;
               bus.s_tlast[i]                   = hd.last;
               bus.s_tdata[i*DATA_W +: DATA_W]  = hd.dat;
            end else begin
               bus.s_tvalid[i]                  = 1'b0;
               bus.s_tlast[i]                   = 1'b0;
               bus.s_tdata[i*DATA_W +: DATA_W]  = '0;
            end
         end
      end
   end

   // FIFO-side monitor: log every transferred beat with its cycle number.
   initial begin : mon
      obs_t o;
      pop_req   = '0;
      cyc       = 0;
      trunc_cnt = 0;
      forever begin
         @(negedge clk);
         cyc++;
         pop_req = bus.s_tvalid & bus.s_tready;
         if (pkt_trunc) trunc_cnt++;
         if (bus.m_tvalid && bus.m_tready) begin
            o.src   = int'(grant_id);
            o.cyc   = cyc;
            o.last  = bus.m_tlast;
            o.trunc = pkt_trunc;
            o.dat   = bus.m_tdata;
            outq.push_back(o);
         end
      end
   end

   initial begin : watchdog
      #50000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_err);
      $fatal(1, "timeout");
   end

   initial begin : main
      int         b;
      int         t0;
      obs_t       o;
      logic [5:0] exp_last;
      logic [5:0] exp_trunc;
      int         exp_tc;
      int         gap4;

      reset_n      = 1'b0;
      bus.m_tready = 1'b1;
      repeat (3) at_neg();

      // Reset state
      chk("rst_busy",      32'(busy), 0);
      chk("rst_fifo_w_en", 32'(fifo_w_en), 0);
      chk("rst_grant_id",  32'(grant_id), 0);
      chk("rst_m_tvalid",  32'(bus.m_tvalid), 0);
      chk("rst_m_tlast",   32'(bus.m_tlast), 0);
      chk("rst_m_tdata",   32'(bus.m_tdata), 0);
      chk("rst_s_tready",  32'(bus.s_tready), 0);
      chk("rst_pkt_trunc", 32'(pkt_trunc), 0);
      at_pos();
      reset_n = 1'b1;

      // Lone source 2, three beats
      at_neg();
      push_beat(2, 8'hA1, 1'b0);
      push_beat(2, 8'hA2, 1'b0);
      push_beat(2, 8'hA3, 1'b1);
      at_neg();
      chk("lone_c0_busy",    32'(busy), 0);
      chk("lone_c0_tvalid",  32'(bus.m_tvalid), 0);
      chk("lone_c0_s_tready",32'(bus.s_tready), 0);
      at_neg();
      chk("lone_c1_grant",   32'(grant_id), 2);
      chk("lone_c1_busy",    32'(busy), 1);
      chk("lone_c1_w_en",    32'(fifo_w_en), 1);
      chk("lone_c1_tdata",   32'(bus.m_tdata), 32'hA1);
      chk("lone_c1_tlast",   32'(bus.m_tlast), 0);
      chk("lone_c1_s_tready",32'(bus.s_tready), 32'h4);
      at_neg();
      chk("lone_c2_tdata",   32'(bus.m_tdata), 32'hA2);
      chk("lone_c2_tlast",   32'(bus.m_tlast), 0);
      at_neg();
      chk("lone_c3_tdata",   32'(bus.m_tdata), 32'hA3);
      chk("lone_c3_tlast",   32'(bus.m_tlast), 1);
      chk("lone_c3_busy",    32'(busy), 1);
      at_neg();
      chk("lone_c4_busy",    32'(busy), 0);
      chk("lone_c4_w_en",    32'(fifo_w_en), 0);
      chk("lone_c4_tvalid",  32'(bus.m_tvalid), 0);
      chk("lone_c4_grant",   32'(grant_id), 2);

      // Round-robin from reset: 4 sources x 3 two-beat packets
      at_pos();
      reset_n = 1'b0;
      at_pos();
      reset_n = 1'b1;
      at_neg();
      b = outq.size();
      for (int k = 0; k < 3; k++)
         for (int s = 0; s < NUM_SRC; s++)
            for (int j = 0; j < 2; j++)
               push_beat(s, 8'(s*16 + k*2 + j), j == 1);
      wait_beats(b + 24, 120, "rr_drain");
      repeat (3) at_neg();
      chk("rr_no_extra", outq.size(), b + 24);
      for (int i = 0; i < 24 && b + i < outq.size(); i++) begin
         o = outq[b + i];
         chk($sformatf("rr%0d_src", i),  o.src, (i/2) % 4);
         chk($sformatf("rr%0d_dat", i),  32'(o.dat), ((i/2) % 4)*16 + (i/8)*2 + (i%2));
         chk($sformatf("rr%0d_last", i), 32'(o.last), i % 2);
         if (i > 0) chk($sformatf("rr%0d_gap", i), o.cyc - outq[b + i - 1].cyc, (i % 2 == 0) ? 2 : 1);
      end

      // Backpressure on source 1 after two beats
      b = outq.size();
      push_beat(1, 8'h50, 1'b0);
      push_beat(1, 8'h51, 1'b0);
      push_beat(1, 8'h52, 1'b0);
      push_beat(1, 8'h53, 1'b1);
      repeat (3) at_neg();
      chk("bp_pre_beats", outq.size(), b + 2);
      at_pos();
      bus.m_tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         at_neg();
         chk($sformatf("bp_stall%0d_s_tready", i), 32'(bus.s_tready), 0);
         chk($sformatf("bp_stall%0d_busy", i),     32'(busy), 1);
         chk($sformatf("bp_stall%0d_grant", i),    32'(grant_id), 1);
         chk($sformatf("bp_stall%0d_beats", i),    outq.size(), b + 2);
      end
      at_pos();
      bus.m_tready = 1'b1;
      wait_beats(b + 4, 20, "bp_drain");
      for (int i = 0; i < 4 && b + i < outq.size(); i++) begin
         o = outq[b + i];
         chk($sformatf("bp%0d_src", i),  o.src, 1);
         chk($sformatf("bp%0d_dat", i),  32'(o.dat), 32'h50 + i);
         chk($sformatf("bp%0d_last", i), 32'(o.last), (i == 3) ? 1 : 0);
      end

      // Reset pulse during beat 2 of a source-3 packet (last_grant is 1 here)
      repeat (2) at_neg();
      b = outq.size();
      push_beat(3, 8'h60, 1'b0);
      push_beat(3, 8'h61, 1'b0);
      push_beat(3, 8'h62, 1'b0);
      push_beat(3, 8'h63, 1'b1);
      repeat (2) at_neg();
      chk("mr_c1_grant", 32'(grant_id), 3);
      at_pos();
      reset_n = 1'b0;
      at_neg();
      push_beat(0, 8'h70, 1'b1);
      at_pos();
      reset_n = 1'b1;
      at_neg();
      chk("mr_c3_busy",     32'(busy), 0);
      chk("mr_c3_s_tready", 32'(bus.s_tready), 0);
      chk("mr_c3_grant",    32'(grant_id), 0);
      chk("mr_c3_tvalid",   32'(bus.m_tvalid), 0);
      chk("mr_c3_w_en",     32'(fifo_w_en), 0);
      at_neg();
      chk("mr_c4_grant",    32'(grant_id), 0);
      chk("mr_c4_tdata",    32'(bus.m_tdata), 32'h70);
      wait_beats(b + 5, 30, "mr_drain");
      if (outq.size() >= b + 5) begin
         chk("mr_b2_src",  outq[b + 2].src, 0);
         chk("mr_b2_last", 32'(outq[b + 2].last), 1);
         chk("mr_b3_src",  outq[b + 3].src, 3);
         chk("mr_b3_dat",  32'(outq[b + 3].dat), 32'h62);
         chk("mr_b4_dat",  32'(outq[b + 4].dat), 32'h63);
         chk("mr_b4_last", 32'(outq[b + 4].last), 1);
      end

      // Six-beat packet from source 0 against a 4-beat limit
`ifdef ARB_PKT_LIMIT_EN
      exp_last  = 6'b101000;
      exp_trunc = 6'b001000;
      exp_tc    = 1;
      gap4      = 2;
`else
      exp_last  = 6'b100000;
      exp_trunc = 6'b000000;
      exp_tc    = 0;
      gap4      = 1;
`endif
      repeat (2) at_neg();
      b  = outq.size();
      t0 = trunc_cnt;
      for (int i = 0; i < 6; i++) push_beat(0, 8'(8'h80 + i), i == 5);
      wait_beats(b + 6, 40, "tr_drain");
      repeat (2) at_neg();
      chk("tr_pulses", trunc_cnt - t0, exp_tc);
      for (int i = 0; i < 6 && b + i < outq.size(); i++) begin
         o = outq[b + i];
         chk($sformatf("tr%0d_src", i),   o.src, 0);
         chk($sformatf("tr%0d_dat", i),   32'(o.dat), 32'h80 + i);
         chk($sformatf("tr%0d_last", i),  32'(o.last), 32'(exp_last[i]));
         chk($sformatf("tr%0d_trunc", i), 32'(o.trunc), 32'(exp_trunc[i]));
         if (i > 0) chk($sformatf("tr%0d_gap", i), o.cyc - outq[b + i - 1].cyc, (i == 4) ? gap4 : 1);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
